// File: rtl/mips_br_pkg.sv
// rtl/mips_br_pkg.sv - branch opcodes and 2-bit predictor counter constants
package mips_br_pkg;

    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_BEQ  = 4'd1;
    localparam logic [3:0] BR_BNE  = 4'd2;
    localparam logic [3:0] BR_BLEZ = 4'd3;
    localparam logic [3:0] BR_BGTZ = 4'd4;
    localparam logic [3:0] BR_BLTZ = 4'd5;
    localparam logic [3:0] BR_BGEZ = 4'd6;
    localparam logic [3:0] BR_BEQL = 4'd7;
    localparam logic [3:0] BR_BNEL = 4'd8;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    function automatic logic [1:0] ctr_update(input logic [1:0] v, input logic taken);
        if (taken) begin
            return (v == ST) ? ST : v + 2'd1;
        end else begin
            return (v == SNT) ? SNT : v - 2'd1;
        end
    endfunction

endpackage

// File: rtl/d_bht.sv
// rtl/d_bht.sv - branch history table of saturating 2-bit counters
module d_bht
    import mips_br_pkg::*;
#(
    parameter int BHT_DEPTH = 16,
    localparam int IDX_W = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] bht_q [BHT_DEPTH];
    logic [1:0] bht_d [BHT_DEPTH];

    always_comb begin
        for (int i = 0; i < BHT_DEPTH; i++) begin
            bht_d[i] = bht_q[i];
        end
        if (upd_en) begin
            bht_d[upd_idx] = ctr_update(bht_q[upd_idx], upd_taken);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= WNT;
            end
        end else begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= bht_d[i];
            end
        end
    end

    // Read from the registered table: a same-cycle update is not bypassed.
    assign rd_taken = bht_q[rd_idx][1];

endmodule

// File: rtl/d_branch_resolve.sv
// rtl/d_branch_resolve.sv - decode-stage branch compare, likely annulment,
// BHT update and retire statistics
module d_branch_resolve
    import mips_br_pkg::*;
#(
    parameter int DW        = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             d_valid,
    input  logic [31:0]      d_pc,
    input  logic [3:0]       br_op,
    input  logic             d_pred_taken,
    input  logic [DW-1:0]    rs_data,
    input  logic [DW-1:0]    rt_data,
    input  logic [31:0]      f_pc,
    output logic             f_pred_taken,
    output logic             judge,
    output logic             null_ci,
    output logic             mispredict,
    output logic [CNT_W-1:0] n_branch,
    output logic [CNT_W-1:0] n_mispred
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             is_br;
    logic             is_likely;
    logic             cond;
    logic             ret;
    logic             rs_neg;
    logic             rs_zero;
    logic [CNT_W-1:0] n_branch_q;
    logic [CNT_W-1:0] n_branch_d;
    logic [CNT_W-1:0] n_mispred_q;
    logic [CNT_W-1:0] n_mispred_d;
    logic             unused_pc;

    assign rs_neg  = rs_data[DW-1];
    assign rs_zero = (rs_data == '0);

    always_comb begin
        cond = 1'b0;
        case (br_op)
            BR_BEQ, BR_BEQL: cond = (rs_data == rt_data);
            BR_BNE, BR_BNEL: cond = (rs_data != rt_data);
            BR_BLEZ:         cond = rs_neg | rs_zero;
            BR_BGTZ:         cond = ~rs_neg & ~rs_zero;
            BR_BLTZ:         cond = rs_neg;
            BR_BGEZ:         cond = ~rs_neg;
            default:         cond = 1'b0;
        endcase
    end

    assign is_br      = d_valid & (br_op >= BR_BEQ) & (br_op <= BR_BNEL);
    assign is_likely  = (br_op == BR_BEQL) | (br_op == BR_BNEL);
    assign judge      = is_br & cond;
    assign null_ci    = d_valid & is_likely & ~cond;
    assign mispredict = is_br & (cond ^ d_pred_taken);

    // A stalled branch retires only on the cycle it leaves D.
    assign ret = is_br & ~stall;

    always_comb begin
        n_branch_d  = n_branch_q;
        n_mispred_d = n_mispred_q;
        if (ret && n_branch_q != CNT_MAX) begin
            n_branch_d = n_branch_q + CNT_ONE;
        end
        if (ret && mispredict && n_mispred_q != CNT_MAX) begin
            n_mispred_d = n_mispred_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_branch_q  <= '0;
            n_mispred_q <= '0;
        end else begin
            n_branch_q  <= n_branch_d;
            n_mispred_q <= n_mispred_d;
        end
    end

    assign n_branch  = n_branch_q;
    assign n_mispred = n_mispred_q;

    d_bht #(
        .BHT_DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (f_pc[IDX_W+1:2]),
        .rd_taken  (f_pred_taken),
        .upd_en    (ret),
        .upd_idx   (d_pc[IDX_W+1:2]),
        .upd_taken (cond)
    );

    assign unused_pc = ^{d_pc[31:IDX_W+2], d_pc[1:0], f_pc[31:IDX_W+2], f_pc[1:0]};

endmodule

// File: tb/tb_d_branch_resolve.sv
// tb/tb_d_branch_resolve.sv - self-checking bench for d_branch_resolve
module tb_d_branch_resolve;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        d_valid = 1'b0;
    logic [31:0] d_pc = '0;
    logic [3:0]  br_op = '0;
    logic        d_pred_taken = 1'b0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [31:0] f_pc = '0;

    logic        f_pred_taken, judge, null_ci, mispredict;
    logic [15:0] n_branch, n_mispred;
    logic        f_pred_taken2, judge2, null_ci2, mispredict2;
    logic [1:0]  n_branch2, n_mispred2;

    int vecs = 0;
    int errs = 0;

    int mbht [16];
    int nb, nm, nb2, nm2;

    always #5 clk = ~clk;

    d_branch_resolve #(.DW(32), .BHT_DEPTH(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .stall(stall), .d_valid(d_valid), .d_pc(d_pc),
        .br_op(br_op), .d_pred_taken(d_pred_taken), .rs_data(rs_data), .rt_data(rt_data),
        .f_pc(f_pc), .f_pred_taken(f_pred_taken), .judge(judge), .null_ci(null_ci),
        .mispredict(mispredict), .n_branch(n_branch), .n_mispred(n_mispred)
    );

    d_branch_resolve #(.DW(32), .BHT_DEPTH(16), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .d_valid(d_valid), .d_pc(d_pc),
        .br_op(br_op), .d_pred_taken(d_pred_taken), .rs_data(rs_data), .rt_data(rt_data),
        .f_pc(f_pc), .f_pred_taken(f_pred_taken2), .judge(judge2), .null_ci(null_ci2),
        .mispredict(mispredict2), .n_branch(n_branch2), .n_mispred(n_mispred2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_cond(input int op, input logic [31:0] rs, input logic [31:0] rt);
        int srs;
        srs = $signed(rs);
        case (op)
            1, 7:    return rs == rt;
            2, 8:    return rs != rt;
            3:       return srs <= 0;
            4:       return srs > 0;
            5:       return srs < 0;
            6:       return srs >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_isbr(input logic v, input int op);
        return v && op >= 1 && op <= 8;
    endfunction

    // Reference model: per-entry integer counters and integer statistics.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mbht[i] <= 1;
            nb <= 0; nm <= 0; nb2 <= 0; nm2 <= 0;
        end else if (m_isbr(d_valid, br_op) && !stall) begin
            if (m_cond(br_op, rs_data, rt_data))
                mbht[d_pc[5:2]] <= (mbht[d_pc[5:2]] >= 3) ? 3 : mbht[d_pc[5:2]] + 1;
            else
                mbht[d_pc[5:2]] <= (mbht[d_pc[5:2]] <= 0) ? 0 : mbht[d_pc[5:2]] - 1;
            nb  <= (nb  >= 65535) ? 65535 : nb + 1;
            nb2 <= (nb2 >= 3) ? 3 : nb2 + 1;
            if (m_cond(br_op, rs_data, rt_data) != d_pred_taken) begin
                nm  <= (nm  >= 65535) ? 65535 : nm + 1;
                nm2 <= (nm2 >= 3) ? 3 : nm2 + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("judge", judge, m_isbr(d_valid, br_op) && m_cond(br_op, rs_data, rt_data));
        chk("null_ci", null_ci, d_valid && (br_op == 7 || br_op == 8) && !m_cond(br_op, rs_data, rt_data));
        chk("mispredict", mispredict,
            m_isbr(d_valid, br_op) && (m_cond(br_op, rs_data, rt_data) != d_pred_taken));
        chk("f_pred_taken", f_pred_taken, mbht[f_pc[5:2]] >= 2);
        chk("n_branch", n_branch, nb);
        chk("n_mispred", n_mispred, nm);
        chk("judge2", judge2, judge);
        chk("null_ci2", null_ci2, null_ci);
        chk("mispredict2", mispredict2, mispredict);
        chk("f_pred_taken2", f_pred_taken2, mbht[f_pc[5:2]] >= 2);
        chk("n_branch2", n_branch2, nb2);
        chk("n_mispred2", n_mispred2, nm2);
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] op,
                         input logic pred, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] fpc, input logic st);
        @(posedge clk);
        #1;
        d_valid = v; d_pc = pc; br_op = op; d_pred_taken = pred;
        rs_data = rs; rt_data = rt; f_pc = fpc; stall = st;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_n_branch", n_branch, 0);
        chk("rst_f_pred", f_pred_taken, 0);

        // Comparator conditions, held in D so nothing retires.
        drive(1, 32'h100, 4'd1, 1, 32'h5, 32'h5, 32'h100, 1);
        chk("beq_eq_judge", judge, 1);
        drive(1, 32'h100, 4'd6, 0, 32'h8000_0000, 32'h0, 32'h100, 1);
        chk("bgez_neg_judge", judge, 0);
        drive(1, 32'h100, 4'd3, 0, 32'h0, 32'h1234, 32'h100, 1);
        chk("blez_zero_judge", judge, 1);
        drive(1, 32'h100, 4'd4, 0, 32'h1, 32'h0, 32'h100, 1);
        chk("bgtz_one_judge", judge, 1);
        drive(1, 32'h100, 4'd8, 0, 32'h7, 32'h7, 32'h100, 1);
        chk("bnel_judge", judge, 0);
        chk("bnel_null_ci", null_ci, 1);
        drive(1, 32'h100, 4'd7, 0, 32'h3, 32'h3, 32'h100, 1);
        chk("beql_null_ci", null_ci, 0);
        chk("beql_judge", judge, 1);
        drive(0, 32'h100, 4'd1, 0, 32'h3, 32'h3, 32'h100, 1);
        chk("bubble_judge", judge, 0);
        chk("bubble_mispred", mispredict, 0);
        drive(1, 32'h100, 4'd9, 1, 32'h3, 32'h3, 32'h100, 0);
        chk("op9_judge", judge, 0);
        chk("op9_mispred", mispredict, 0);

        // Stalled branch retires exactly once.
        repeat (3) drive(1, 32'h40, 4'd1, 1, 32'h9, 32'h9, 32'h40, 1);
        chk("stall_f_pred", f_pred_taken, 0);
        drive(1, 32'h40, 4'd1, 1, 32'h9, 32'h9, 32'h40, 0);
        chk("stall_nb_before", n_branch, 0);
        drive(0, 32'h0, 4'd0, 0, 32'h0, 32'h0, 32'h40, 0);
        chk("stall_nb_after", n_branch, 1);
        chk("stall_bht_wt", f_pred_taken, 1);
        chk("stall_nm", n_mispred, 0);

        // Counter saturation at both ends.
        repeat (4) drive(1, 32'h44, 4'd1, 1, 32'h2, 32'h2, 32'h44, 0);
        drive(0, 32'h0, 4'd0, 0, 32'h0, 32'h0, 32'h44, 0);
        chk("sat_taken_pred", f_pred_taken, 1);
        repeat (4) drive(1, 32'h44, 4'd2, 0, 32'h2, 32'h2, 32'h44, 0);
        drive(0, 32'h0, 4'd0, 0, 32'h0, 32'h0, 32'h44, 0);
        chk("sat_nt_pred", f_pred_taken, 0);
        drive(1, 32'h44, 4'd1, 0, 32'h2, 32'h2, 32'h44, 0);
        chk("sat_mispred", mispredict, 1);
        drive(0, 32'h0, 4'd0, 0, 32'h0, 32'h0, 32'h44, 0);
        chk("sat_floor_pred", f_pred_taken, 0);
        chk("sat_nb", n_branch, 10);
        chk("sat_nm", n_mispred, 1);

        // Mispredict and no read bypass on same index.
        drive(1, 32'h48, 4'd1, 0, 32'h4, 32'h4, 32'h48, 0);
        chk("mp_mispred", mispredict, 1);
        chk("mp_judge", judge, 1);
        chk("mp_old_pred", f_pred_taken, 0);
        drive(0, 32'h0, 4'd0, 0, 32'h0, 32'h0, 32'h48, 0);
        chk("mp_new_pred", f_pred_taken, 1);
        chk("mp_nm", n_mispred, 2);
        chk("mp_nb", n_branch, 11);
        chk("mp_nb2_sat", n_branch2, 3);
        chk("mp_nm2", n_mispred2, 2);

        // Asynchronous reset during a stall.
        drive(1, 32'h48, 4'd1, 1, 32'h4, 32'h4, 32'h48, 1);
        drive(1, 32'h48, 4'd1, 1, 32'h4, 32'h4, 32'h48, 1);
        #1 reset = 1'b0;
        #1;
        chk("arst_nb", n_branch, 0);
        chk("arst_nm", n_mispred, 0);
        chk("arst_f_pred", f_pred_taken, 0);
        chk("arst_judge", judge, 1);
        chk("arst_nb2", n_branch2, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        repeat (5) drive(1, 32'h48, 4'd1, 1, 32'h4, 32'h4, 32'h48, 0);
        drive(0, 32'h0, 4'd0, 0, 32'h0, 32'h0, 32'h48, 0);
        chk("post_nb", n_branch, 5);
        chk("post_nb2_sat", n_branch2, 3);
        chk("post_nm", n_mispred, 0);
        chk("post_f_pred", f_pred_taken, 1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
